cuckoo_match_collector: RTL and testbench
=========================================

Name: cuckoo_match_collector

Overview:
- Sits directly downstream of the L5 cuckoo lookup stage.
- Consumes the per-byte compare/suffix results for both the case-sensitive and nocase lanes.
- Re-associates each result with the payload byte offset that produced it, and queues match events in a small FIFO.
- A downstream rule-verification stage drains that FIFO through a valid/ready handshake.

Parameters:
- PIPE_LAT, 4, cycles from an enabled stage-1 hash update to the corresponding compare_out/suffix (1 hash reg + 2 RAM reads + 1 compare reg)
- OFF_W, 16, payload byte offset width
- DEPTH, 16, event FIFO depth; power of two, >= 4

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  same byte-advance strobe driven to the lookup stage
- pkt_start  in  1  first payload byte of a packet; qualified by enable
- compare_out  in  2  case-lane hit vector from the lookup stage; nonzero = hit
- suffix  in  2  case-lane suffix id
- compare_out_nocase  in  2  nocase-lane hit vector
- suffix_nocase  in  2  nocase-lane suffix id
- m_valid  out  1  event available
- m_ready  in  1  consumer accepts the event
- m_data  out  5+OFF_W  {nocase[1], cmp[2], suffix[2], offset[OFF_W]}, MSB first
- overflow  out  1  sticky; set when any event is dropped
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset, asynchronous: delay line, offset counter, FIFO pointers and count, overflow, and drop counter all go to 0. m_valid=0, m_data=0.
- Offset counter:
  - On enable & pkt_start: the byte is tagged offset 0; counter loads 1.
  - On enable & !pkt_start: the byte is tagged with the current counter; counter increments, saturating at 2^OFF_W-1.
  - Without enable: counter holds.
- Delay line: PIPE_LAT-deep shift register of {tag_valid=enable, offset}. It advances every cycle regardless of enable, matching the free-running RAM/compare stages.
- At the delay-line output, if tag_valid=1:
  - case event requested when compare_out!=0
  - nocase event requested when compare_out_nocase!=0
- If tag_valid=0, lookup outputs are ignored. They are stale repeats of the held stage-1 address.
- An in-flight tag keeps its own offset. A pkt_start or counter saturation does not retag entries already in the delay line.
- FIFO write, 0/1/2 entries per cycle:
  - Free space = DEPTH - count, sampled before this cycle's pop. A same-cycle pop does not create space.
  - Two requests and free>=2: write case at wr_ptr, nocase at wr_ptr+1.
  - Two requests and free==1: write case, drop nocase.
  - free==0: drop all requests.
  - Each drop sets overflow, which is cleared only by rst.
- FIFO read:
  - m_valid = count!=0.
  - m_data is the head entry, driven combinationally from storage.
  - Pop on m_valid & m_ready.
  - m_data must not change while m_valid=1 & m_ready=0.
- Simultaneous push and pop: count += pushes - pop. Pointers wrap modulo DEPTH.
- fifo_level = count, registered.
- Throughput: a sustained 2 events/cycle with m_ready=1 saturates the FIFO; this is intentional and handled by the drop policy.
- Latency: event written PIPE_LAT+1 cycles after the enabled byte; m_valid rises the following cycle.

Optional Feature:
- Macro CUCKOO_MC_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [15:0], a count of dropped events, saturating at 16'hFFFF.
  - A cycle dropping both lane events adds 2.
  - Reset to 0.
- Undefined: port and counter absent; overflow flag only.

Test Plan:
- Reset release, then enable=1 for 8 bytes with pkt_start on byte 0, and case compare_out=2'b01, suffix=2'b10 aligned to byte 5 -> one event m_data={0,01,10,16'd5} visible 6 cycles after byte 5's enable; fifo_level=1; overflow=0.
- Same byte hits both lanes (case 2'b10/sfx 0, nocase 2'b01/sfx 3) at offset 7 with m_ready=1 -> two consecutive events: case {0,10,00,7} first, then nocase {1,01,11,7}.
- enable toggled 1,0,0,1 with compare_out held nonzero throughout -> exactly 2 events, offsets n and n+1; held-address repeats are ignored.
- m_ready=0, 20 single-lane hits -> fifo_level=16, overflow=1, drop_cnt=4 (macro on). Then m_ready=1 -> 16 events in offset order, none altered while stalled.
- FIFO at 15 entries, dual hit -> case accepted, nocase dropped, level=16. Same cycle with a pop -> level stays 15+1-1=15; nocase is still dropped.
- pkt_start mid-stream with 3 tags in flight -> in-flight events keep their old offsets; the next byte reports offset 0. rst asserted while m_valid=1 -> m_valid=0 and fifo_level=0 immediately (asynchronous).

Source files
------------

// File: rtl/cuckoo_match_collector.sv
// Re-associates cuckoo lookup hits with their payload byte offset and queues events in a FIFO.
// Optional CUCKOO_MC_DROP_CNT_EN adds a saturating drop_cnt output.
module cuckoo_match_collector #(
  parameter int PIPE_LAT = 4,
  parameter int OFF_W    = 16,
  parameter int DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    pkt_start,
  input  logic [1:0]              compare_out,
  input  logic [1:0]              suffix,
  input  logic [1:0]              compare_out_nocase,
  input  logic [1:0]              suffix_nocase,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [5+OFF_W-1:0]      m_data,
  output logic                    overflow,
`ifdef CUCKOO_MC_DROP_CNT_EN
  output logic [15:0]             drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 5 + OFF_W;

  logic [OFF_W-1:0]                off_cnt;
  logic [PIPE_LAT-1:0]             dl_vld;
  logic [PIPE_LAT-1:0][OFF_W-1:0]  dl_off;

  logic           req_case, req_nc;
  logic [DW-1:0]  req_case_d, req_nc_d;

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_n1;
  logic [CW-1:0]  count, free;
  logic           we_a, we_b, pop;
  logic [DW-1:0]  ent_a;
  logic [1:0]     n_push, n_drop;

  // Offset counter: pkt_start tags 0 and reloads 1; otherwise tag current and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_cnt <= '0;
    end else if (enable) begin
      if (pkt_start)
        off_cnt <= OFF_W'(1);
      else if (off_cnt != '1)
        off_cnt <= off_cnt + OFF_W'(1);
    end
  end

  // Free-running delay line, aligned with the hash/RAM/compare stages of the lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld <= '0;
      dl_off <= '0;
    end else begin
      dl_vld[0] <= enable;
      dl_off[0] <= pkt_start ? '0 : off_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_off[i] <= dl_off[i-1];
      end
    end
  end

  // Request stage: lookup results are only meaningful for tags that were enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_case   <= 1'b0;
      req_nc     <= 1'b0;
      req_case_d <= '0;
      req_nc_d   <= '0;
    end else begin
      req_case   <= dl_vld[PIPE_LAT-1] && (compare_out != 2'b00);
      req_nc     <= dl_vld[PIPE_LAT-1] && (compare_out_nocase != 2'b00);
      req_case_d <= {1'b0, compare_out, suffix, dl_off[PIPE_LAT-1]};
      req_nc_d   <= {1'b1, compare_out_nocase, suffix_nocase, dl_off[PIPE_LAT-1]};
    end
  end

  assign pop       = (count != '0) && m_ready;
  assign wr_ptr_n1 = wr_ptr + AW'(1);

  // Space is judged before this cycle's pop; case lane has priority over nocase.
  always_comb begin
    free   = CW'(DEPTH) - count;
    we_a   = 1'b0;
    we_b   = 1'b0;
    ent_a  = req_case_d;
    n_drop = 2'd0;
    if (req_case && req_nc) begin
      if (free >= CW'(2)) begin
        we_a = 1'b1;
        we_b = 1'b1;
      end else if (free == CW'(1)) begin
        we_a   = 1'b1;
        n_drop = 2'd1;
      end else begin
        n_drop = 2'd2;
      end
    end else if (req_case || req_nc) begin
      ent_a = req_case ? req_case_d : req_nc_d;
      if (free != '0)
        we_a = 1'b1;
      else
        n_drop = 2'd1;
    end
    n_push = {1'b0, we_a} + {1'b0, we_b};
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[wr_ptr]    <= ent_a;
    if (we_b) mem[wr_ptr_n1] <= req_nc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
      if (n_drop != 2'd0)
        overflow <= 1'b1;
    end
  end

`ifdef CUCKOO_MC_DROP_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_cuckoo_match_collector.sv
// Randomized bench for cuckoo_match_collector against a queue-based event model.
module tb_cuckoo_match_collector;

  localparam int PL = 4;
  localparam int OW = 5;
  localparam int D  = 16;
  localparam int DW = 5 + OW;
  localparam int OMAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic enable, pkt_start, m_ready;
  logic [1:0] compare_out, suffix, compare_out_nocase, suffix_nocase;
  logic m_valid, overflow;
  logic [DW-1:0] m_data;
  logic [$clog2(D):0] fifo_level;
`ifdef CUCKOO_MC_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  cuckoo_match_collector #(.PIPE_LAT(PL), .OFF_W(OW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_start(pkt_start),
    .compare_out(compare_out), .suffix(suffix),
    .compare_out_nocase(compare_out_nocase), .suffix_nocase(suffix_nocase),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .overflow(overflow),
`ifdef CUCKOO_MC_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .fifo_level(fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: byte tags by cycle, event queue, sticky flags.
  logic [DW-1:0] q[$];
  bit            ring_en[8];
  int            ring_off[8];
  int            k, m_off, m_drops;
  bit            m_ovf;
  bit            p_case, p_nc;
  logic [DW-1:0] p_case_d, p_nc_d;

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin ring_en[i] = 0; ring_off[i] = 0; end
    m_off = 0; m_drops = 0; m_ovf = 0;
    p_case = 0; p_nc = 0; p_case_d = '0; p_nc_d = '0;
  endtask

  task automatic push_event(input bit req, input logic [DW-1:0] d, inout int free);
    if (req) begin
      if (free > 0) begin q.push_back(d); free--; end
      else begin m_ovf = 1; m_drops++; end
    end
  endtask

  task automatic step(input bit en, input bit ps, input logic [1:0] c, input logic [1:0] s,
                      input logic [1:0] cn, input logic [1:0] sn, input bit rdy);
    int free, tag, old_off;
    bit c_case, c_nc, old_en;
    @(posedge clk); #1;
    enable = en; pkt_start = ps; compare_out = c; suffix = s;
    compare_out_nocase = cn; suffix_nocase = sn; m_ready = rdy;
    @(negedge clk);
    check("m_valid", m_valid, q.size() != 0);
    check("fifo_level", fifo_level, q.size());
    check("overflow", overflow, m_ovf);
    if (q.size() != 0) check("m_data", m_data, q[0]);
`ifdef CUCKOO_MC_DROP_CNT_EN
    check("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
`endif
    old_en  = ring_en[(k + 4) & 7];
    old_off = ring_off[(k + 4) & 7];
    c_case  = old_en && (c != 0);
    c_nc    = old_en && (cn != 0);
    tag = ps ? 0 : m_off;
    if (en) m_off = ps ? 1 : ((m_off < OMAX) ? m_off + 1 : OMAX);
    ring_en[k & 7]  = en;
    ring_off[k & 7] = tag;
    free = D - q.size();
    if (q.size() != 0 && rdy) void'(q.pop_front());
    push_event(p_case, p_case_d, free);
    push_event(p_nc, p_nc_d, free);
    p_case = c_case; p_case_d = {1'b0, c, s, OW'(old_off)};
    p_nc   = c_nc;   p_nc_d   = {1'b1, cn, sn, OW'(old_off)};
    k++;
  endtask

  task automatic phase(input int n, input int pen, input int pps, input int phit, input int prdy);
    logic [1:0] c, cn;
    for (int i = 0; i < n; i++) begin
      c  = ($urandom_range(99) < phit) ? 2'($urandom_range(3, 1)) : 2'b00;
      cn = ($urandom_range(99) < phit) ? 2'($urandom_range(3, 1)) : 2'b00;
      step($urandom_range(99) < pen, $urandom_range(99) < pps, c, 2'($urandom_range(3)),
           cn, 2'($urandom_range(3)), $urandom_range(99) < prdy);
    end
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    enable = 0; pkt_start = 0; m_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 0; pkt_start = 0; m_ready = 0;
    compare_out = 0; suffix = 0; compare_out_nocase = 0; suffix_nocase = 0;
    k = 0;
    model_clear();
    #12;
    check("init_m_valid", m_valid, 0);
    check("init_level", fifo_level, 0);
    check("init_overflow", overflow, 0);
    check("init_m_data", m_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // 8 bytes from packet start; case hit for byte 5 arrives PL cycles later.
    for (int i = 0; i < 14; i++) begin
      step(i < 8, i == 0, (i == 9) ? 2'b01 : 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
      if (i == 10) check("t1_not_yet", m_valid, 0);
      if (i == 11) begin
        check("t1_data", m_data, {1'b0, 2'b01, 2'b10, 5'd5});
        check("t1_level", fifo_level, 1);
      end
    end

    phase(300, 70, 5, 40, 80);
    phase(200, 100, 0, 90, 0);
    phase(400, 100, 2, 50, 50);
    phase(300, 30, 10, 60, 100);
    phase(100, 100, 3, 70, 0);
    check("pre_rst_valid", m_valid, 1);
    async_reset();
    phase(300, 100, 0, 20, 90);
    phase(400, 60, 4, 80, 60);
    phase(60, 0, 0, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
